// File: rtl/cv32e40s_tb_vp_periph.sv
// Virtual peripheral for the CV32E40S core testbench: test status/exit
// registers, one-shot timer interrupts and a delayed debug-request pulse.
// Sits on the data bus next to the RAM; the outer decode gates req_i and
// this block only looks at the word offset addr_i[7:2].
module cv32e40s_tb_vp_periph #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned TIMER_W    = 32,
    parameter int unsigned DBG_HOLD   = 4,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic               debug_req_o,
    output logic               tests_passed_o,
    output logic               tests_failed_o,
    output logic               exit_valid_o,
    output logic [31:0]        exit_value_o
);

    localparam int unsigned HOLD_W = (DBG_HOLD > 1) ? $clog2(DBG_HOLD) : 1;
    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DBG_HOLD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ASSERT = 2'd2;

    logic [5:0]         word;
    logic               wr_en;
    logic [TIMER_W-1:0] wr_val;
    logic               wr_status;
    logic               wr_exit;
    logic               wr_dbg;
    logic               wr_pend;

    logic               passed_reg;
    logic               failed_reg;
    logic               exit_valid_reg;
    logic [31:0]        exit_value_reg;
    logic               rvalid_reg;
    logic [31:0]        rdata_reg;
    logic [31:0]        rdata_next;
    logic [NUM_IRQ-1:0] pend_reg;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] tmr_expire;
    logic [TIMER_W-1:0] tmr_cnt [NUM_IRQ];
    logic [1:0]         state_reg;
    logic [TIMER_W-1:0] dbg_cnt_reg;
    logic [HOLD_W-1:0]  hold_reg;

    // Byte address bits outside the word offset are decoded by the outer bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:8], addr_i[1:0]};

    assign word      = addr_i[7:2];
    assign wr_en     = req_i & we_i & (be_i == 4'hF);
    assign wr_val    = wdata_i[TIMER_W-1:0];
    assign wr_status = wr_en && (word == 6'h00);
    assign wr_exit   = wr_en && (word == 6'h01);
    assign wr_dbg    = wr_en && (word == 6'h02);
    assign wr_pend   = wr_en && (word == 6'h03);
    assign w1c_mask  = wr_pend ? wdata_i[NUM_IRQ-1:0] : '0;

    assign gnt_o          = req_i;
    assign rvalid_o       = rvalid_reg;
    assign rdata_o        = rdata_reg;
    assign irq_o          = pend_reg;
    assign debug_req_o    = (state_reg == ST_ASSERT);
    assign tests_passed_o = passed_reg;
    assign tests_failed_o = failed_reg;
    assign exit_valid_o   = exit_valid_reg;
    assign exit_value_o   = exit_value_reg;

    // Sticky pass/fail flags and the first-write-wins exit code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            passed_reg     <= 1'b0;
            failed_reg     <= 1'b0;
            exit_valid_reg <= 1'b0;
            exit_value_reg <= '0;
        end else begin
            if (wr_status && (wdata_i == PASS_MAGIC)) begin
                passed_reg <= 1'b1;
            end
            if (wr_status && (wdata_i == 32'd1)) begin
                failed_reg <= 1'b1;
            end
            if (wr_exit && !exit_valid_reg) begin
                exit_valid_reg <= 1'b1;
                exit_value_reg <= wdata_i;
            end
        end
    end

    // One-shot timers. The counter holds the number of cycles still to go
    // before the pending bit becomes visible, so a load of N is stored as
    // N-1 and a load of 1 expires on the write edge itself.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_tmr
        logic               wr_tmr;
        logic [TIMER_W-1:0] cnt_reg;

        assign wr_tmr = wr_en && (word == 6'(4 + 2 * gi));

        // Load on write (rewrite restarts), otherwise count down to zero and stop.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg <= '0;
            end else if (wr_tmr) begin
                cnt_reg <= (wr_val > ONE) ? (wr_val - ONE) : '0;
            end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - ONE;
            end
        end

        assign tmr_cnt[gi]    = cnt_reg;
        assign tmr_expire[gi] = wr_tmr ? (wr_val == ONE) : (cnt_reg == ONE);
    end

    // Pending bits: write-1-to-clear, with a same-cycle expiry taking priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= (pend_reg & ~w1c_mask) | tmr_expire;
        end
    end

    // Debug request sequencer. From IDLE/WAIT the pulse starts D+1 cycles
    // after the write; a rewrite during the pulse first drops the request
    // for one cycle so the core sees a fresh rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            dbg_cnt_reg <= '0;
            hold_reg    <= '0;
        end else if (wr_dbg) begin
            if (state_reg == ST_ASSERT) begin
                state_reg   <= ST_WAIT;
                dbg_cnt_reg <= wr_val;
            end else if (wr_val == '0) begin
                state_reg   <= ST_ASSERT;
                dbg_cnt_reg <= '0;
                hold_reg    <= HOLD_LAST;
            end else begin
                state_reg   <= ST_WAIT;
                dbg_cnt_reg <= wr_val - ONE;
            end
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (dbg_cnt_reg == '0) begin
                        state_reg <= ST_ASSERT;
                        hold_reg  <= HOLD_LAST;
                    end else begin
                        dbg_cnt_reg <= dbg_cnt_reg - ONE;
                    end
                end
                ST_ASSERT: begin
                    if (hold_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        hold_reg <= hold_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Read multiplexer; odd timer slots, unmapped offsets and absent channels read 0.
    always_comb begin
        rdata_next = '0;
        case (word)
            6'h00:   rdata_next = {30'b0, failed_reg, passed_reg};
            6'h01:   rdata_next = exit_value_reg;
            6'h02:   rdata_next = 32'(dbg_cnt_reg);
            6'h03:   rdata_next = 32'(pend_reg);
            default: begin
                for (int k = 0; k < int'(NUM_IRQ); k++) begin
                    if (word == 6'(4 + 2 * k)) begin
                        rdata_next = 32'(tmr_cnt[k]);
                    end
                end
            end
        endcase
    end

    // Single-cycle response: every accepted access answers in the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= req_i;
            rdata_reg  <= (req_i && !we_i) ? rdata_next : '0;
        end
    end

endmodule
